csa_pipe: RTL and testbench

Parametrised, pipelined carry-select adder/subtractor, the WIDTH-generic successor to the fixed 8-bit carry-select adder.
- Operand width is split into NBLK = WIDTH/BLK carry-select blocks.
- The blocks are grouped into STAGES pipeline segments. Each segment is resolved in one clock and its carry is registered into the next segment.
- Valid/ready handshake at both ends, full throughput (one result per clock), add/subtract mode and signed-overflow flag.
- Sits in the datapath as a drop-in arithmetic unit for wide counters and accumulators.

---
 rtl/csa_pipe_pkg.sv | 35 +++
 rtl/csa_block.sv | 31 +++
 rtl/csa_pipe.sv | 173 +++++++++++++++++
 tb/tb_csa_pipe.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pipe_pkg.sv
// csa_pipe_pkg
//   Shared configuration for the pipelined carry-select adder/subtractor:
//   default parameter values, derived geometry helpers (number of blocks,
//   segment width, blocks per segment) and the parameter-legality predicate.
//   No ports; imported by csa_pipe and csa_block.
package csa_pipe_pkg;

    localparam int CSA_WIDTH_DEF  = 32;
    localparam int CSA_BLK_DEF    = 4;
    localparam int CSA_STAGES_DEF = 2;

    // Total carry-select blocks across the operand (NBLK).
    function automatic int csa_nblk(input int width, input int blk);
        return width / blk;
    endfunction

    // Bits resolved per pipeline segment (SEG_W).
    function automatic int csa_seg_w(input int width, input int stages);
        return width / stages;
    endfunction

    // Carry-select blocks per pipeline segment (SPB).
    function automatic int csa_spb(input int width, input int blk, input int stages);
        return (width / stages) / blk;
    endfunction

    // Legal when WIDTH splits evenly into STAGES segments of whole blocks
    // and there is at least one block per segment.
    function automatic bit csa_cfg_ok(input int width, input int blk, input int stages);
        if (width < 1 || blk < 1 || stages < 1) return 1'b0;
        if ((width % (blk * stages)) != 0) return 1'b0;
        return (stages <= (width / blk));
    endfunction

endpackage

// File: rtl/csa_block.sv
// csa_block
//   One BLK-bit carry-select cell: two speculative sums (carry-in 0 and 1)
//   are formed in parallel and the late-arriving real carry-in picks one.
// Ports:
//   a, b  [BLK]  operand slices (b already inverted for subtraction)
//   cin          real carry into the block (select line)
//   sum   [BLK]  selected block sum
//   cout         selected carry out of the block
module csa_block
    import csa_pipe_pkg::*;
#(
    parameter int BLK = CSA_BLK_DEF
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] sum,
    output logic           cout
);

    logic [BLK:0] sum_c0;
    logic [BLK:0] sum_c1;

    // Both speculative sums are independent of cin, so only the final
    // mux sits on the carry path.
    assign sum_c0 = {1'b0, a} + {1'b0, b};
    assign sum_c1 = {1'b0, a} + {1'b0, b} + (BLK+1)'(1);

    assign {cout, sum} = cin ? sum_c1 : sum_c0;

endmodule

// File: rtl/csa_pipe.sv
// csa_pipe
//   Pipelined carry-select adder/subtractor. The operand is cut into STAGES
//   segments of SEG_W bits; segment k is resolved in stage k, and its carry
//   plus the untouched upper operand bits are registered into stage k+1.
//   Elastic valid/ready pipeline, one result per clock, results in order.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   operand handshake (in_ready independent of in_valid)
//   a, b [WIDTH]          operands
//   cin                   carry in (ignored when sub=1)
//   sub                   0: a+b+cin, 1: a-b (as a + ~b + 1)
//   out_valid / out_ready result handshake
//   sum [WIDTH]           result modulo 2^WIDTH
//   cout                  carry out of MSB (no-borrow flag when subtracting)
//   ovf                   signed overflow
module csa_pipe
    import csa_pipe_pkg::*;
#(
    parameter int WIDTH  = CSA_WIDTH_DEF,
    parameter int BLK    = CSA_BLK_DEF,
    parameter int STAGES = CSA_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NBLK  = csa_nblk(WIDTH, BLK);
    localparam int SEG_W = csa_seg_w(WIDTH, STAGES);
    localparam int SPB   = csa_spb(WIDTH, BLK, STAGES);

    if (!csa_cfg_ok(WIDTH, BLK, STAGES) || (STAGES > NBLK)) begin : g_bad_cfg
        $error("csa_pipe: WIDTH must be a multiple of BLK*STAGES and 1 <= STAGES <= WIDTH/BLK");
    end

    logic [WIDTH-1:0]  b_eff;
    logic              c0;
    logic [STAGES-1:0] vld_all;
    logic [STAGES-1:0] adv;

    assign b_eff = sub ? ~b : b;
    assign c0    = sub | cin;

    // Stage k may advance unless it and every stage after it are full while
    // the consumer stalls. Written in closed form so no advance bit feeds
    // another combinationally.
    for (genvar k = 0; k < STAGES; k++) begin : g_adv
        localparam logic [STAGES-1:0] LOW_MASK = STAGES'((1 << k) - 1);
        assign adv[k] = out_ready | ~(&(vld_all | LOW_MASK));
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int SLSB = k * SEG_W;
        localparam int MSB  = (k + 1) * SEG_W - 1;

        logic [WIDTH-1:0] src_a, src_b, src_sum;
        logic             src_ci, src_vld;
        logic [SEG_W-1:0] seg_sum;
        logic             seg_co, seg_cm;

        logic [WIDTH-1:0] sum_d, sum_q, a_d, a_q, b_d, b_q;
        logic             cy_d, cy_q, cm_d, cm_q, v_d, v_q;

        if (k == 0) begin : g_src
            assign src_a   = a;
            assign src_b   = b_eff;
            assign src_ci  = c0;
            assign src_sum = '0;
            assign src_vld = in_valid;
        end else begin : g_src
            assign src_a   = g_stg[k-1].a_q;
            assign src_b   = g_stg[k-1].b_q;
            assign src_ci  = g_stg[k-1].cy_q;
            assign src_sum = g_stg[k-1].sum_q;
            assign src_vld = g_stg[k-1].v_q;
        end

        for (genvar j = 0; j < SPB; j++) begin : g_blk
            localparam int LSB = SLSB + j * BLK;
            logic           ci, co;
            logic [BLK-1:0] s;

            if (j == 0) begin : g_ci
                assign ci = src_ci;
            end else begin : g_ci
                assign ci = g_blk[j-1].co;
            end

            csa_block #(.BLK(BLK)) u_blk (
                .a    (src_a[LSB +: BLK]),
                .b    (src_b[LSB +: BLK]),
                .cin  (ci),
                .sum  (s),
                .cout (co)
            );

            assign seg_sum[j*BLK +: BLK] = s;
        end

        assign seg_co = g_blk[SPB-1].co;
        // Carry into the segment MSB recovered from the MSB sum bit; only the
        // last segment's value matters (signed overflow).
        assign seg_cm = src_a[MSB] ^ src_b[MSB] ^ seg_sum[SEG_W-1];

        always_comb begin
            v_d   = v_q;
            sum_d = sum_q;
            a_d   = a_q;
            b_d   = b_q;
            cy_d  = cy_q;
            cm_d  = cm_q;
            if (adv[k]) begin
                v_d = src_vld;
                if (src_vld) begin
                    sum_d                 = src_sum;
                    sum_d[SLSB +: SEG_W]  = seg_sum;
                    a_d                   = src_a;
                    b_d                   = src_b;
                    cy_d                  = seg_co;
                    cm_d                  = seg_cm;
                end
            end
        end

        // ---- stage k register boundary ----
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                sum_q <= '0;
                a_q   <= '0;
                b_q   <= '0;
                cy_q  <= 1'b0;
                cm_q  <= 1'b0;
            end else begin
                v_q   <= v_d;
                sum_q <= sum_d;
                a_q   <= a_d;
                b_q   <= b_d;
                cy_q  <= cy_d;
                cm_q  <= cm_d;
            end
        end

        assign vld_all[k] = v_q;

        // Operand bits have no consumer after the last segment, and the
        // MSB carry is only consumed from the last segment.
        if (k == STAGES - 1) begin : g_tail
            logic unused_ab;
            assign unused_ab = ^{a_q, b_q};
        end else begin : g_tail
            logic unused_cm;
            assign unused_cm = cm_q;
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = vld_all[STAGES-1];
    assign sum       = g_stg[STAGES-1].sum_q;
    assign cout      = g_stg[STAGES-1].cy_q;
    assign ovf       = g_stg[STAGES-1].cy_q ^ g_stg[STAGES-1].cm_q;

endmodule

// File: tb/tb_csa_pipe.sv
// tb_csa_pipe
//   Directed bench for csa_pipe (WIDTH=32, BLK=4, STAGES=2) with an
//   arithmetic reference model and an in-order result queue.
module tb_csa_pipe;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready;
    logic [W-1:0] a, b, sum;
    logic         cin, sub;
    logic         out_valid, out_ready;
    logic         cout, ovf;

    int           n_cmp  = 0;
    int           n_fail = 0;
    logic [33:0]  sb_q[$];

    csa_pipe #(.WIDTH(32), .BLK(4), .STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: signed/unsigned arithmetic on wide integers, {cout, ovf, sum}.
    function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic mc, input logic ms);
        longint sa, sb, r;
        logic   co, ov;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        if (ms) begin
            r  = sa - sb;
            co = (ma >= mb);
        end else begin
            r  = sa + sb + longint'(mc);
            co = (({1'b0, ma} + {1'b0, mb} + 33'(mc)) > 33'h0_FFFF_FFFF);
        end
        ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        return {co, ov, r[31:0]};
    endfunction

    // Scoreboard: sampled on the falling edge, between active edges.
    initial begin : scoreboard
        logic        stall_prev;
        logic [33:0] held;
        logic [33:0] e;
        stall_prev = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb_q.delete();
                stall_prev = 1'b0;
            end else begin
                if (stall_prev)
                    check("sb_stall_hold", 64'({out_valid, cout, ovf, sum}), 64'({1'b1, held}));
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        check("sb_unexpected_out", 64'(out_valid), 64'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_result", 64'({cout, ovf, sum}), 64'(e));
                    end
                end
                if (in_valid && in_ready)
                    sb_q.push_back(model(a, b, cin, sub));
                stall_prev = out_valid && !out_ready;
                held       = {cout, ovf, sum};
            end
        end
    end

    // Present one operand (called just after a rising edge); returns just
    // after the edge that accepted it, with in_valid still high.
    task automatic present(input logic [31:0] ta, input logic [31:0] tb_, input logic tc,
                           input logic ts, output int tries);
        logic acc;
        a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 20) begin
            @(negedge clk);
            tries++;
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        check("present_accept", 64'(acc), 64'd1);
    endtask

    task automatic expect_next(input string name, input logic [31:0] es, input logic ec,
                               input logic eo);
        int w;
        bit got;
        w = 0; got = 1'b0;
        while (!got && w < 20) begin
            @(negedge clk);
            w++;
            got = out_valid;
        end
        check({name, "_valid"}, 64'(got), 64'd1);
        check({name, "_sum"},   64'(sum),  64'(es));
        check({name, "_cout"},  64'(cout), 64'(ec));
        check({name, "_ovf"},   64'(ovf),  64'(eo));
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum",       64'(sum),       64'd0);
        check("rst_cout_ovf",  64'({cout, ovf}), 64'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // 1: carry through every block and the stage boundary, exact latency
        present(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, t);
        in_valid = 1'b0;
        @(negedge clk);
        check("t1_not_yet_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_sum",   64'(sum),  64'h0);
        check("t1_cout",  64'(cout), 64'd1);
        check("t1_ovf",   64'(ovf),  64'd0);
        @(posedge clk); #1;

        // 2: subtraction with and without borrow
        present(32'd5, 32'd7, 1'b0, 1'b1, t);
        present(32'd7, 32'd5, 1'b0, 1'b1, t);
        in_valid = 1'b0;
        expect_next("t2_5m7", 32'hFFFF_FFFE, 1'b0, 1'b0);
        expect_next("t2_7m5", 32'h0000_0002, 1'b1, 1'b0);

        // 3: signed overflow in both directions
        present(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, t);
        present(32'h8000_0000, 32'h1, 1'b0, 1'b1, t);
        in_valid = 1'b0;
        expect_next("t3_maxp1", 32'h8000_0000, 1'b0, 1'b1);
        expect_next("t3_minm1", 32'h7FFF_FFFF, 1'b1, 1'b1);

        // 4: eight back-to-back ops, full throughput
        fork
            begin
                int tr;
                for (int i = 0; i < 8; i++) begin
                    present(32'(i), 32'h10, 1'b1, 1'b0, tr);
                    check("t4_in_ready_first_try", 64'(tr), 64'd1);
                end
                in_valid = 1'b0;
            end
            begin
                int w;
                w = 0;
                @(negedge clk);
                while (!out_valid && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                for (int k = 0; k < 8; k++) begin
                    if (k > 0) @(negedge clk);
                    check("t4_valid", 64'(out_valid), 64'd1);
                    check("t4_sum",   64'(sum), 64'(32'h11 + k));
                end
            end
        join
        @(posedge clk); #1;

        // 5: fill while stalled, hold 3 cycles, then drain in order
        out_ready = 1'b0;
        present(32'h100, 32'h2000, 1'b0, 1'b0, t);
        present(32'h101, 32'h2000, 1'b0, 1'b0, t);
        a = 32'h102;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_in_ready_low", 64'(in_ready),  64'd0);
            check("t5_out_valid",    64'(out_valid), 64'd1);
            check("t5_sum_stable",   64'(sum),       64'h2100);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        expect_next("t5_r0", 32'h2100, 1'b0, 1'b0);
        in_valid = 1'b0;
        expect_next("t5_r1", 32'h2101, 1'b0, 1'b0);
        expect_next("t5_r2", 32'h2102, 1'b0, 1'b0);

        // 6: asynchronous reset mid-stream discards in-flight results
        present(32'hAAA0, 32'h1, 1'b0, 1'b0, t);
        present(32'hAAA1, 32'h1, 1'b0, 1'b0, t);
        present(32'hAAA2, 32'h1, 1'b0, 1'b0, t);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_out_valid", 64'(out_valid), 64'd0);
        check("t6_rst_sum",       64'(sum),       64'h0);
        check("t6_rst_cout_ovf",  64'({cout, ovf}), 64'd0);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("t6_in_ready", 64'(in_ready), 64'd1);
        check("t6_idle",     64'(out_valid), 64'd0);
        present(32'h1234, 32'h1111, 1'b0, 1'b0, t);
        in_valid = 1'b0;
        expect_next("t6_post", 32'h2345, 1'b0, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        check("sb_drain", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
